blockx_gen2: RTL and testbench
==============================

# blockx_gen2

Parametrised successor to the sap1 single-register/1K-table block: a PIO-mapped slave with NUM_REGS general registers and a TBL_DEPTH-entry table behind one synchronous RAM. Adds a uniform two-cycle read pipeline, out-of-range error signalling, and a hardware table-clear engine controlled through register 0. Sits on the sap1 PIO bus alongside the other leaf blocks.

## Interface
- DATA_W, 32, data width of registers, table entries and bus data
- NUM_REGS, 4, register count (2..256); reg 0 is CTRL
- TBL_DEPTH, 1024, table entries (2..32768, any value)
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- pio_cmd_vld  in  1  command strobe, one command per cycle
- pio_rw  in  1  1 = write, 0 = read
- pio_addr  in  16  addr[15]=0 register space, 1 table space; index = addr[14:0]
- pio_data_w  in  DATA_W  write data
- pio_data_r  out  DATA_W  read data, valid with pio_rd_vld
- pio_rd_vld  out  1  one-cycle read-response pulse
- pio_err  out  1  one-cycle pulse, aligned as pio_rd_vld would be for a read (N+2)
- tbl_busy  out  1  table clear in progress

## Operation
- Register space: index < NUM_REGS valid. Reg 0 CTRL: bit0 CLR (write 1 starts clear; reads 0), bit1 BUSY (RO, = tbl_busy), other bits read 0. Regs 1..NUM_REGS-1 plain R/W, full width.
- Table space: index < TBL_DEPTH valid.
- Out of range (either space): write dropped; read returns all-zeros data with rd_vld; pio_err pulses in both cases.
- Clear FSM: IDLE -> CLEAR on CTRL write with bit0=1 (ignored if already CLEAR). CLEAR writes zero to entry cnt, cnt 0..TBL_DEPTH-1, one per cycle; at cnt=TBL_DEPTH-1 -> IDLE.
- During CLEAR, table-space commands: writes dropped, reads return 0; both pulse pio_err. Register-space commands serviced normally.
- Table RAM has one write port: PIO writes and clear engine never collide because PIO table writes are blocked in CLEAR.

## Timing
- Every read: command at cycle N -> pio_rd_vld=1 and pio_data_r at N+2 (stage 1: RAM/reg read, stage 2: output register). Writes produce no response; pio_err for a bad write at N+2.
- Full throughput: back-to-back commands every cycle; responses in order, no gaps inserted.
- Write at N, read same location at N+1: returns the new value (write commits at end of N).
- Same-cycle read and write impossible (one command per cycle).
- CLR write at N: tbl_busy=1 from N+1 through N+TBL_DEPTH; entry k zeroed in cycle N+1+k; tbl_busy=0 at N+TBL_DEPTH+1. CTRL read reflects BUSY with the normal 2-cycle latency, sampled at stage 1.
- Table read at cycle N+TBL_DEPTH+1 returns legal data, no err.
- pio_data_r holds last value when pio_rd_vld=0.
- Reset: pio_rd_vld=0, pio_err=0, pio_data_r=0, tbl_busy=0, FSM IDLE, cnt=0, regs 1..NUM_REGS-1 =0, read pipeline flushed. Table contents not reset. Reset mid-clear aborts; table left partially cleared; in-flight reads dropped (no rd_vld).

## Structure
- Package blockx_gen2_pkg: clear-FSM state enum (IDLE, CLEAR), CTRL bit index constants (CTRL_CLR=0, CTRL_BUSY=1), address-space bit constant (SPACE_BIT=15).
- Index widths derived via $clog2 of NUM_REGS/TBL_DEPTH inside the block.
- Sub-module blockx_gen2_tbl_ram: single-port synchronous RAM, DATA_W x TBL_DEPTH, one-cycle registered read, write-before-read is not required (covered by pipeline ordering), no reset.

## Test plan
- Reset then read reg 1 and CTRL -> rd_vld at N+2, data 0x0000_0000 both; no err.
- Write reg 2=0xA5A5_0001, read reg 2 next cycle -> 0xA5A5_0001 at read+2; back-to-back reads of regs 1,2,3 -> three consecutive rd_vld pulses in order.
- Write table[1023]=0x1234_5678, table[0]=0xCAFE_F00D; read both -> same values; write table[1024] with TBL_DEPTH=1024 -> err pulse, table[0] unchanged; read reg 4 with NUM_REGS=4 -> data 0, err=1.
- Fill table[5]=0xFFFF_FFFF, write CTRL=0x1 -> tbl_busy high exactly 1024 cycles; table read during clear -> data 0 with err; reg 1 R/W during clear works; after busy drops table[5] reads 0, no err.
- Start clear, assert reset at cycle 100 of clear -> tbl_busy=0 next cycle, FSM IDLE, table[500] retains pre-clear value, pending read produces no rd_vld.
- Parameter sweep TBL_DEPTH=1000, NUM_REGS=3, DATA_W=16: table[999] R/W ok, table[1000] err, clear lasts 1000 cycles.

Source files
------------

// File: rtl/blockx_gen2_pkg.sv
// blockx_gen2_pkg: shared types and constants for the blockx_gen2 PIO slave
package blockx_gen2_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  localparam int CTRL_CLR  = 0;
  localparam int CTRL_BUSY = 1;
  localparam int SPACE_BIT = 15;
endpackage

// File: rtl/blockx_gen2_tbl_ram.sv
// blockx_gen2_tbl_ram: single-port synchronous table RAM with registered read
module blockx_gen2_tbl_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/blockx_gen2.sv
// blockx_gen2: PIO slave with general registers, a RAM-backed table and a table-clear engine
module blockx_gen2
  import blockx_gen2_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 4,
  parameter int TBL_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pio_cmd_vld,
  input  logic              pio_rw,
  input  logic [15:0]       pio_addr,
  input  logic [DATA_W-1:0] pio_data_w,
  output logic [DATA_W-1:0] pio_data_r,
  output logic              pio_rd_vld,
  output logic              pio_err,
  output logic              tbl_busy
);
  localparam int RI_W = $clog2(NUM_REGS);
  localparam int TI_W = $clog2(TBL_DEPTH);
  clr_state_e        state_q, state_d;
  logic [TI_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [14:0]       idx;
  logic [RI_W-1:0]   ridx;
  logic              is_tbl, reg_ok, tbl_ok, cmd_ok, reg_wr, tbl_wr, clr_go;
  logic [DATA_W-1:0] reg_rd, ram_wdata, ram_rdata;
  logic [TI_W-1:0]   ram_addr;
  logic              ram_we;
  logic              s1_vld_q, s1_err_q, s1_tbl_q, rd_vld_q, err_q;
  logic [DATA_W-1:0] s1_data_q, data_q;
  assign idx        = pio_addr[14:0];
  assign ridx       = idx[RI_W-1:0];
  assign is_tbl     = pio_addr[SPACE_BIT];
  assign tbl_busy   = state_q == CLEAR;
  assign pio_rd_vld = rd_vld_q;
  assign pio_err    = err_q;
  assign pio_data_r = data_q;
  // 16-bit compares so TBL_DEPTH=32768 still fits
  always_comb begin
    reg_ok = {1'b0, idx} < 16'(NUM_REGS);
    tbl_ok = ({1'b0, idx} < 16'(TBL_DEPTH)) && !tbl_busy;
    cmd_ok = is_tbl ? tbl_ok : reg_ok;
    reg_wr = pio_cmd_vld && pio_rw && !is_tbl && reg_ok;
    tbl_wr = pio_cmd_vld && pio_rw && is_tbl && tbl_ok;
    clr_go = reg_wr && ridx == '0 && pio_data_w[CTRL_CLR];
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tbl_busy) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TI_W'(TBL_DEPTH - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (clr_go) state_d = CLEAR;
    reg_rd = '0;
    if (ridx == '0) reg_rd[CTRL_BUSY] = tbl_busy;
    for (int i = 1; i < NUM_REGS; i++)
      if (ridx == RI_W'(i)) reg_rd = regs_q[i];
    ram_we    = tbl_busy || tbl_wr;
    ram_addr  = tbl_busy ? cnt_q : idx[TI_W-1:0];
    ram_wdata = tbl_busy ? '0 : pio_data_w;
  end
  blockx_gen2_tbl_ram #(.DATA_W(DATA_W), .DEPTH(TBL_DEPTH), .AW(TI_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_tbl_q  <= 1'b0;
      s1_data_q <= '0;
      rd_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= pio_cmd_vld && !pio_rw;
      s1_err_q  <= pio_cmd_vld && !cmd_ok;
      s1_tbl_q  <= is_tbl && cmd_ok;
      s1_data_q <= (!is_tbl && reg_ok) ? reg_rd : '0;
      rd_vld_q  <= s1_vld_q;
      err_q     <= s1_err_q;
      if (s1_vld_q) data_q <= s1_tbl_q ? ram_rdata : s1_data_q;
      for (int i = 1; i < NUM_REGS; i++)
        if (reg_wr && ridx == RI_W'(i)) regs_q[i] <= pio_data_w;
    end
  end
endmodule

// File: tb/tb_blockx_gen2.sv
// tb_blockx_gen2: directed self-checking bench for blockx_gen2 (default and swept parameters)
module tb_blockx_gen2;
  logic        clk = 1'b0, reset = 1'b1;
  logic        vld, rw, rvld, err, busy;
  logic [15:0] addr;
  logic [31:0] wd, rd;
  logic        vld2, rw2, rvld2, err2, busy2;
  logic [15:0] addr2, wd2, rd2;
  int          n_chk = 0, n_fail = 0, cyc = 0, t0;

  blockx_gen2 dut (
    .clk(clk), .reset(reset), .pio_cmd_vld(vld), .pio_rw(rw), .pio_addr(addr),
    .pio_data_w(wd), .pio_data_r(rd), .pio_rd_vld(rvld), .pio_err(err), .tbl_busy(busy)
  );
  blockx_gen2 #(.DATA_W(16), .NUM_REGS(3), .TBL_DEPTH(1000)) dut2 (
    .clk(clk), .reset(reset), .pio_cmd_vld(vld2), .pio_rw(rw2), .pio_addr(addr2),
    .pio_data_w(wd2), .pio_data_r(rd2), .pio_rd_vld(rvld2), .pio_err(err2), .tbl_busy(busy2)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic w, input logic [15:0] a, input logic [31:0] d);
    vld = v; rw = w; addr = a; wd = d;
  endtask
  task automatic drv2(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    vld2 = v; rw2 = w; addr2 = a; wd2 = d;
  endtask

  task automatic test_reset;
    drv(0, 0, 0, 0); drv2(0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) step;
    reset = 1'b0;
    n_chk++;
    if ({rvld, err, busy, rd} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL reset_state got vld/err/busy=%b%b%b data=%h want 000 00000000", rvld, err, busy, rd);
    end
    n_chk++;
    if ({rvld2, err2, busy2, rd2} !== {3'b000, 16'h0}) begin
      n_fail++; $display("FAIL reset_state2 got vld/err/busy=%b%b%b data=%h want 000 0000", rvld2, err2, busy2, rd2);
    end
    drv(1, 0, 16'h0001, 0); step;
    drv(1, 0, 16'h0000, 0); step;
    drv(0, 0, 0, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_reg1 got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_ctrl got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
    step;
    n_chk++;
    if (rvld !== 1'b0) begin
      n_fail++; $display("FAIL reset_single_pulse got vld=%b want 0", rvld);
    end
  endtask

  task automatic test_regs;
    drv(1, 1, 16'h0002, 32'hA5A5_0001); step;
    drv(1, 0, 16'h0002, 0); step;
    drv(0, 0, 0, 0); step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL wr_then_rd_reg2 got vld/err=%b%b data=%h want 10 a5a50001", rvld, err, rd);
    end
    drv(1, 1, 16'h0001, 32'h1111_1111); step;
    drv(1, 1, 16'h0003, 32'h3333_3333); step;
    drv(1, 0, 16'h0001, 0); step;
    drv(1, 0, 16'h0002, 0); step;
    drv(1, 0, 16'h0003, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h1111_1111}) begin
      n_fail++; $display("FAIL b2b_reg1 got vld/err=%b%b data=%h want 10 11111111", rvld, err, rd);
    end
    step;
    drv(0, 0, 0, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL b2b_reg2 got vld/err=%b%b data=%h want 10 a5a50001", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h3333_3333}) begin
      n_fail++; $display("FAIL b2b_reg3 got vld/err=%b%b data=%h want 10 33333333", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, rd} !== {1'b0, 32'h3333_3333}) begin
      n_fail++; $display("FAIL data_hold got vld=%b data=%h want 0 33333333", rvld, rd);
    end
  endtask

  task automatic test_table;
    drv(1, 1, 16'h83FF, 32'h1234_5678); step;
    drv(1, 1, 16'h8000, 32'hCAFE_F00D); step;
    drv(1, 0, 16'h83FF, 0); step;
    drv(1, 0, 16'h8000, 0); step;
    drv(0, 0, 0, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h1234_5678}) begin
      n_fail++; $display("FAIL tbl_1023 got vld/err=%b%b data=%h want 10 12345678", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL tbl_0 got vld/err=%b%b data=%h want 10 cafef00d", rvld, err, rd);
    end
    drv(1, 1, 16'h8400, 32'hDEAD_DEAD); step;
    drv(0, 0, 0, 0); step;
    n_chk++;
    if ({rvld, err} !== 2'b01) begin
      n_fail++; $display("FAIL tbl_oor_wr got vld/err=%b%b want 01", rvld, err);
    end
    step;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_single_pulse got err=%b want 0", err);
    end
    drv(1, 0, 16'h8000, 0); step;
    drv(1, 0, 16'h0004, 0); step;
    drv(0, 0, 0, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL tbl_0_kept got vld/err=%b%b data=%h want 10 cafef00d", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL reg_oor_rd got vld/err=%b%b data=%h want 11 00000000", rvld, err, rd);
    end
  endtask

  task automatic test_clear;
    drv(1, 1, 16'h8005, 32'hFFFF_FFFF); step;
    drv(1, 1, 16'h81F4, 32'h5A5A_5A5A); step;
    drv(1, 1, 16'h0000, 32'h0000_0001); step;
    drv(0, 0, 0, 0);
    t0 = cyc;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_busy_rise got busy=%b want 1", busy);
    end
    drv(1, 0, 16'h8005, 0); step;
    drv(1, 0, 16'h0000, 0); step;
    drv(1, 1, 16'h0001, 32'hBEEF_0001);
    n_chk++;
    if ({rvld, err, rd} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL tbl_rd_in_clear got vld/err=%b%b data=%h want 11 00000000", rvld, err, rd);
    end
    step;
    drv(1, 0, 16'h0001, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h2}) begin
      n_fail++; $display("FAIL ctrl_busy_rd got vld/err=%b%b data=%h want 10 00000002", rvld, err, rd);
    end
    step;
    drv(0, 0, 0, 0); step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'hBEEF_0001}) begin
      n_fail++; $display("FAIL reg_rw_in_clear got vld/err=%b%b data=%h want 10 beef0001", rvld, err, rd);
    end
    for (int i = 0; i < 2000 && busy; i++) step;
    n_chk++;
    if (busy !== 1'b0 || cyc - t0 != 1024) begin
      n_fail++; $display("FAIL clr_duration got busy=%b cycles=%0d want 0 1024", busy, cyc - t0);
    end
    drv(1, 0, 16'h8005, 0); step;
    drv(1, 0, 16'h81F4, 0); step;
    drv(0, 0, 0, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL tbl5_cleared got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL tbl500_cleared got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
  endtask

  task automatic test_reset_mid_clear;
    drv(1, 1, 16'h81F4, 32'hDEAD_BEEF); step;
    drv(1, 1, 16'h8032, 32'h0000_0050); step;
    drv(1, 1, 16'h0000, 32'h0000_0001); step;
    drv(0, 0, 0, 0);
    repeat (99) step;
    drv(1, 0, 16'h0001, 0); step;
    drv(0, 0, 0, 0);
    reset = 1'b1; step;
    n_chk++;
    if ({rvld, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_clear got vld/busy=%b%b want 00", rvld, busy);
    end
    reset = 1'b0; step;
    n_chk++;
    if ({rvld, err, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_read_dropped got vld/err/busy=%b%b%b want 000", rvld, err, busy);
    end
    drv(1, 0, 16'h81F4, 0); step;
    drv(1, 0, 16'h8032, 0); step;
    drv(1, 0, 16'h0001, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL tbl500_retained got vld/err=%b%b data=%h want 10 deadbeef", rvld, err, rd);
    end
    step;
    drv(1, 0, 16'h0000, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL tbl50_partial_clear got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
    step;
    drv(0, 0, 0, 0);
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reg1_reset got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
    step;
    n_chk++;
    if ({rvld, err, rd} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL ctrl_idle got vld/err=%b%b data=%h want 10 00000000", rvld, err, rd);
    end
  endtask

  task automatic test_sweep;
    drv2(1, 1, 16'h83E7, 16'hBEEF); step;
    drv2(1, 0, 16'h83E7, 0); step;
    drv2(1, 1, 16'h83E8, 16'h1234); step;
    drv2(1, 0, 16'h0003, 0);
    n_chk++;
    if ({rvld2, err2, rd2} !== {2'b10, 16'hBEEF}) begin
      n_fail++; $display("FAIL sw_tbl999 got vld/err=%b%b data=%h want 10 beef", rvld2, err2, rd2);
    end
    step;
    drv2(0, 0, 0, 0);
    n_chk++;
    if ({rvld2, err2} !== 2'b01) begin
      n_fail++; $display("FAIL sw_tbl1000_err got vld/err=%b%b want 01", rvld2, err2);
    end
    step;
    n_chk++;
    if ({rvld2, err2, rd2} !== {2'b11, 16'h0}) begin
      n_fail++; $display("FAIL sw_reg3_oor got vld/err=%b%b data=%h want 11 0000", rvld2, err2, rd2);
    end
    drv2(1, 1, 16'h0000, 16'h0001); step;
    drv2(0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 2000 && busy2; i++) step;
    n_chk++;
    if (busy2 !== 1'b0 || cyc - t0 != 1000) begin
      n_fail++; $display("FAIL sw_clr_duration got busy=%b cycles=%0d want 0 1000", busy2, cyc - t0);
    end
    drv2(1, 0, 16'h83E7, 0); step;
    drv2(0, 0, 0, 0); step;
    n_chk++;
    if ({rvld2, err2, rd2} !== {2'b10, 16'h0}) begin
      n_fail++; $display("FAIL sw_tbl999_cleared got vld/err=%b%b data=%h want 10 0000", rvld2, err2, rd2);
    end
  endtask

  initial begin
    test_reset;
    test_regs;
    test_table;
    test_clear;
    test_reset_mid_clear;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
